// File: rtl/mul_arb_pkg.sv
// Shared types and widths for the multiplier arbiter: FSM encoding, datapath
// widths and the watchdog counter sizing helper.
package mul_arb_pkg;

  localparam int OP_W  = 32;
  localparam int RES_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Counter must be able to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping around, returned as one-hot grant plus binary index.
module rr_picker
  import mul_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int   c;
    logic found;
    grant = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one multi-cycle multiplier between NUM_REQ requesters: round-robin
// accept, single-cycle start pulse, wait for finish (with watchdog), respond.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_a,
  input  logic [OP_W*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]      req_signed,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [RES_W-1:0]        resp_res,
  output logic                    resp_err,
  output logic                    mul_start,
  output logic [OP_W-1:0]         mul_a,
  output logic [OP_W-1:0]         mul_b,
  output logic                    mul_signed,
  input  logic [RES_W-1:0]        mul_res,
  input  logic                    mul_finish,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; req_ready is only ever raised in IDLE and resp_valid only in RESP.
  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    mul_a_q, mul_a_d;
  logic [OP_W-1:0]    mul_b_q, mul_b_d;
  logic               mul_signed_q, mul_signed_d;
  logic [RES_W-1:0]   resp_res_q, resp_res_d;
  logic               resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_idx_d    = gnt_idx_q;
    cnt_d        = cnt_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    mul_signed_d = mul_signed_q;
    resp_res_d   = resp_res_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          mul_a_d      = req_a[pick_idx*OP_W +: OP_W];
          mul_b_d      = req_b[pick_idx*OP_W +: OP_W];
          mul_signed_d = req_signed[pick_idx];
          gnt_idx_d    = pick_idx;
          rr_ptr_d     = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A finish in the same cycle as the timeout still counts as success.
        if (mul_finish) begin
          resp_res_d = mul_res;
          resp_err_d = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          resp_res_d = '0;
          resp_err_d = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready[gnt_idx_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gnt_idx_q    <= '0;
      cnt_q        <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_signed_q <= 1'b0;
      resp_res_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_idx_q    <= gnt_idx_d;
      cnt_q        <= cnt_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_signed_q <= mul_signed_d;
      resp_res_q   <= resp_res_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) ? pick_grant : '0;
  assign resp_valid = (state_q == ST_RESP) ? (NUM_REQ'(1) << gnt_idx_q) : '0;
  assign mul_start  = (state_q == ST_ISSUE);
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_signed = mul_signed_q;
  assign resp_res   = resp_res_q;
  assign resp_err   = resp_err_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle 32x32 multiplier unit (start/finish handshake) between NUM_REQ requesters. Accepts one operand pair at a time, issues a single-cycle start pulse, waits for finish, and returns the registered product to the granted requester. A watchdog aborts a transaction when finish never arrives. Sits between client datapaths and the shared multiplier.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- TIMEOUT, 255, maximum WAIT cycles before abort (≥ 1)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant/accept
- req_a  in  32*NUM_REQ  operand a, requester i at [32i+31:32i]
- req_b  in  32*NUM_REQ  operand b, same packing
- req_signed  in  NUM_REQ  1 = signed multiply
- resp_valid  out  NUM_REQ  one-hot response valid
- resp_ready  in  NUM_REQ  per-requester response accept
- resp_res  out  64  product of current response
- resp_err  out  1  1 = transaction aborted by watchdog
- mul_start  out  1  start pulse to multiplier
- mul_a, mul_b  out  32 each  operands to multiplier
- mul_signed  out  1  signedness to multiplier
- mul_res  in  64  multiplier product
- mul_finish  in  1  multiplier done

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, picker selects the first set bit at or after rr_ptr (wrapping); req_ready[g] high combinationally that cycle only; on handshake latch a/b/signed into mul_a/mul_b/mul_signed, latch grant index g, rr_ptr <= (g+1) mod NUM_REQ, go ISSUE. No req_valid: stay, req_ready = 0.
- ISSUE: mul_start = 1 for exactly this cycle; clear watchdog counter; go WAIT.
- WAIT: mul_start = 0, operands held stable. mul_finish = 1: capture mul_res into resp_res, resp_err <= 0, go RESP. Else counter++; counter reaching TIMEOUT: resp_res <= 0, resp_err <= 1, go RESP.
- RESP: resp_valid[g] = 1, resp_res/resp_err held; on resp_ready[g] go IDLE. resp_ready on other bits ignored.
- req_ready is 0 outside IDLE; at most one bit of req_ready and resp_valid ever set.
- mul_finish outside WAIT (including late finish after abort) ignored.
- Product is passed through unmodified; sign handling is the multiplier's job.

## Timing
- Reset (rst low, asynchronous): state IDLE, rr_ptr 0, counter 0; req_ready 0, resp_valid 0, resp_res 0, resp_err 0, mul_start 0, mul_a/mul_b 0, mul_signed 0. Reset mid-transaction drops it silently; no response emitted.
- Accept at edge T: mul_start high cycle T+1; WAIT from T+2.
- mul_finish seen high in cycle F: resp_valid high from F+1 until resp_ready sampled high.
- Abort: resp_valid at latest TIMEOUT+1 cycles after entering WAIT.
- Back-to-back: next accept no earlier than cycle after response handshake (IDLE cycle); minimum 4 cycles per transaction plus multiplier latency.
- mul_finish in the same cycle the counter hits TIMEOUT: finish wins, resp_err = 0.
- Requesters may drop req_valid before grant; no request latched unless handshake occurs.

## Structure
- Package mul_arb_pkg: state enum (IDLE/ISSUE/WAIT/RESP), operand width 32, result width 64, counter width derived from TIMEOUT.
- Sub-module rr_picker: combinational round-robin select (req vector, ptr -> one-hot grant, index, any).
- Top holds FSM, operand/result registers, watchdog counter.

## Test plan
- Single request: req 0, a=7, b=6, signed=0, multiplier finish after 3 cycles -> mul_start one pulse at T+1, resp_valid[0] with resp_res=42, resp_err=0.
- Signed pass-through: a=0xFFFFFFFD, b=5, signed=1, model returns 0xFFFFFFFFFFFFFFF1 -> mul_signed=1 during WAIT, resp_res=0xFFFFFFFFFFFFFFF1.
- Fairness: both req_valid held for 4 transactions after reset -> grant order 0,1,0,1; never two ready bits.
- Watchdog: TIMEOUT=4, finish never asserted -> resp_err=1, resp_res=0 exactly 5 cycles after WAIT entry; later stray finish in IDLE ignored.
- Backpressure: resp_ready low 10 cycles -> resp_valid/resp_res stable, req_ready stays 0 with req_valid[1] pending; grant to 1 in first IDLE cycle after handshake.
- Reset mid-WAIT: rst low during WAIT -> all outputs 0 immediately, no resp_valid after release; next request served normally from rr_ptr 0.
